gfx_strip_rmw: RTL
==================

# gfx_strip_rmw

Single-strip write-combining read-modify-write engine downstream of the graphics address calculator. It accepts one pixel per request as strip address, mask begin/end bit indices and colour, and holds one SW-bit strip locally. Hits merge in one cycle; on a miss it writes back the dirty strip and fetches the new one over a simple req/ack memory port. It feeds the memory arbiter and serves the plot/line/fill engines.

## Interface
- SW, 256: strip width in bits (32, 64, 128, 256)
- BN, $clog2(SW)-1: bit-index MSB
- SB, $clog2(SW/8): byte-offset bits ignored in the tag
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; one clock, asynchronous and active-low
- req_valid_i  in  1  pixel request valid
- req_ready_o  out  1  engine can accept a request
- req_addr_i  in  32  strip byte address (calculator address output)
- req_mb_i  in  BN+1  first bit of pixel in strip (inclusive)
- req_me_i  in  BN+1  last bit of pixel in strip (inclusive)
- req_color_i  in  64  pixel colour, bit 0 lands at mb
- req_rop_i  in  2  00 copy, 01 AND, 10 OR, 11 XOR
- flush_i  in  1  level request: write back a dirty strip
- flush_done_o  out  1  one-cycle pulse: flush complete
- mem_req_o  out  1  memory cycle request
- mem_we_o  out  1  1 write, 0 read
- mem_addr_o  out  32  strip address, low SB bits zero
- mem_wdata_o  out  SW  write data
- mem_ack_i  in  1  memory cycle done; read data valid
- mem_rdata_i  in  SW  read data

## Operation
- State: strip[SW-1:0], tag[31:SB], valid, dirty, pending request registers.
- FSM states: IDLE, WB, RD, MERGE. req_ready_o = (state==IDLE).
- IDLE, req_valid_i: compare req_addr_i[31:SB] to tag.
  - Hit (valid and equal): merge into strip at the clock edge, set dirty, stay IDLE.
  - Miss: capture request. If dirty, go to WB. If not dirty, go to RD.
- IDLE, no req_valid_i, flush_i high:
  - Dirty: go to WB in flush mode.
  - Not dirty: pulse flush_done_o, stay IDLE.
  - A request in the same cycle takes priority. The flush waits because flush_i is level-held.
- WB: mem_req_o=1, mem_we_o=1, mem_addr_o={tag,SB'0}, mem_wdata_o=strip. On mem_ack_i, clear dirty.
  - Flush mode: pulse flush_done_o, go to IDLE. valid stays set.
  - Otherwise: go to RD.
- RD: mem_req_o=1, mem_we_o=0, mem_addr_o={pending addr[31:SB],SB'0}. On mem_ack_i: strip<=mem_rdata_i, tag<=pending tag, valid<=1, go to MERGE.
- MERGE: merge the pending pixel, set dirty, go to IDLE.
- Merge rule: for each bit i with mb<=i<=me, c=color[i-mb] and s=strip[i].
  - Result by rop: copy→c, AND→s&c, OR→s|c, XOR→s^c.
  - Bits outside [mb,me] are unchanged.
- Boundary rules:
  - me<mb (strip overrun): clip, affecting bits mb..SW-1 only.
  - Span wider than 64: bits beyond color[63] use 0.
  - mb==me: exactly one bit.

## Timing
- Reset values:
  - State IDLE, valid=0, dirty=0, strip=0, tag=0.
  - req_ready_o=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, flush_done_o=0.
- All mem_* outputs are registered. They are stable while mem_req_o is high and drop in the cycle after the ack edge.
- mem_ack_i is ignored in IDLE and MERGE.
- Hit throughput: 1 pixel/clock. The merged strip is visible to the next-cycle request, so back-to-back hits to the same strip chain correctly.
- Clean miss: accept at cycle 0, mem_req_o from cycle 1, ack at cycle k, MERGE at k+1, ready at k+2.
- Dirty miss: adds one WB cycle plus the write ack latency before RD.
- Reset mid-transaction aborts immediately. Dirty data is lost, and mem_req_o drops asynchronously.

## Test plan
- Clean miss: addr 0x1000, mb=8, me=15, color 0xA5, copy, ack after 3 cycles.
  - Expect a read of 0x1000 with rdata=0.
  - Then dirty=1 and strip[15:8]=0xA5, all other bits unchanged.
- Hit stream: 4 back-to-back requests to 0x1000, mb=0/8/16/24, colors 11/22/33/44, copy.
  - Ready is held high and no mem_req_o is issued.
  - strip[31:0]=0x44332211.
- Dirty miss: after the hit stream, request 0x1020.
  - Expect a write of 0x1000 with wdata[31:0]=0x44332211, then a read of 0x1020, then the merge.
- ROP and clip: strip bits 255:248=0xF0, mb=252, me=3, color 0xFF, XOR → bits 255:252 become 0, bits 251:248 stay 0.
- Flush, both cases:
  - Dirty: exactly one write, then a flush_done_o pulse.
  - Clean: flush_done_o in the same cycle after flush_i rises, no memory cycle.
  - flush_i and req_valid_i together: the request is served first.
- Async reset while RD is waiting for ack: mem_req_o falls without a clock, and valid=dirty=0.
  - A later ack is ignored.

Source files
------------

// File: rtl/gfx_strip_rmw.sv
// Single-strip write-combining read-modify-write engine for the graphics pipeline.
// Hits merge in place in one cycle; misses write back a dirty strip and refill over req/ack.
module gfx_strip_rmw #(
    parameter int unsigned SW = 256,
    parameter int unsigned BN = $clog2(SW) - 1,
    parameter int unsigned SB = $clog2(SW / 8)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [31:0]   req_addr_i,
    input  logic [BN:0]   req_mb_i,
    input  logic [BN:0]   req_me_i,
    input  logic [63:0]   req_color_i,
    input  logic [1:0]    req_rop_i,
    input  logic          flush_i,
    output logic          flush_done_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_addr_o,
    output logic [SW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [SW-1:0] mem_rdata_i
);
    localparam int unsigned TW = 32 - SB;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWb    = 2'd1;
    localparam logic [1:0] StRd    = 2'd2;
    localparam logic [1:0] StMerge = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] strip_q, strip_d;
    logic [TW-1:0] tag_q, tag_d;
    logic          valid_q, valid_d;
    logic          dirty_q, dirty_d;
    logic [TW-1:0] p_tag_q, p_tag_d;
    logic [BN:0]   p_mb_q, p_mb_d;
    logic [BN:0]   p_me_q, p_me_d;
    logic [63:0]   p_color_q, p_color_d;
    logic [1:0]    p_rop_q, p_rop_d;
    logic          flush_mode_q, flush_mode_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [SW-1:0] mem_wdata_q, mem_wdata_d;
    logic          hit;
    logic          unused_addr;

    // Span mask runs mb..me, or mb..top of strip when me<mb (overrun clip).
    function automatic logic [SW-1:0] merge_strip(input logic [SW-1:0] s,
                                                  input logic [BN:0]   mb,
                                                  input logic [BN:0]   me,
                                                  input logic [63:0]   color,
                                                  input logic [1:0]    rop);
        logic [SW-1:0] ones;
        logic [SW-1:0] mask;
        logic [SW-1:0] col;
        logic [SW-1:0] res;
        ones = '1;
        col  = SW'(color);
        col  = col << mb;
        mask = ones << mb;
        if (me >= mb) begin
            mask = mask & (ones >> ~me);
        end
        unique case (rop)
            2'b00:   res = col;
            2'b01:   res = s & col;
            2'b10:   res = s | col;
            default: res = s ^ col;
        endcase
        return (s & ~mask) | (res & mask);
    endfunction

    assign unused_addr = ^req_addr_i[SB-1:0];
    assign hit         = valid_q && (req_addr_i[31:SB] == tag_q);
    assign req_ready_o = (state_q == StIdle);
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_comb begin
        state_d      = state_q;
        strip_d      = strip_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        p_tag_d      = p_tag_q;
        p_mb_d       = p_mb_q;
        p_me_d       = p_me_q;
        p_color_d    = p_color_q;
        p_rop_d      = p_rop_q;
        flush_mode_d = flush_mode_q;
        flush_done_o = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (hit) begin
                        strip_d = merge_strip(strip_q, req_mb_i, req_me_i, req_color_i, req_rop_i);
                        dirty_d = 1'b1;
                    end else begin
                        p_tag_d      = req_addr_i[31:SB];
                        p_mb_d       = req_mb_i;
                        p_me_d       = req_me_i;
                        p_color_d    = req_color_i;
                        p_rop_d      = req_rop_i;
                        flush_mode_d = 1'b0;
                        state_d      = dirty_q ? StWb : StRd;
                    end
                end else if (flush_i) begin
                    if (dirty_q) begin
                        flush_mode_d = 1'b1;
                        state_d      = StWb;
                    end else begin
                        flush_done_o = 1'b1;
                    end
                end
            end
            StWb: begin
                if (mem_ack_i) begin
                    dirty_d = 1'b0;
                    if (flush_mode_q) begin
                        flush_done_o = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (mem_ack_i) begin
                    strip_d = mem_rdata_i;
                    tag_d   = p_tag_q;
                    valid_d = 1'b1;
                    state_d = StMerge;
                end
            end
            StMerge: begin
                strip_d = merge_strip(strip_q, p_mb_q, p_me_q, p_color_q, p_rop_q);
                dirty_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Memory port is registered from the next state so it is stable for the whole cycle.
        if (state_d == StWb) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q, {SB{1'b0}}};
            mem_wdata_d = strip_q;
        end else if (state_d == StRd) begin
            mem_req_d  = 1'b1;
            mem_addr_d = {p_tag_d, {SB{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            strip_q      <= '0;
            tag_q        <= '0;
            valid_q      <= 1'b0;
            dirty_q      <= 1'b0;
            p_tag_q      <= '0;
            p_mb_q       <= '0;
            p_me_q       <= '0;
            p_color_q    <= '0;
            p_rop_q      <= '0;
            flush_mode_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            strip_q      <= strip_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            p_tag_q      <= p_tag_d;
            p_mb_q       <= p_mb_d;
            p_me_q       <= p_me_d;
            p_color_q    <= p_color_d;
            p_rop_q      <= p_rop_d;
            flush_mode_q <= flush_mode_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule
